// File: rtl/fetch_ctrl.sv
// Fetch sequencer for the 256x8 instruction ROM: owns the PC, steps over 1/2-byte
// instructions, redirects on branch/rti and enters the ISR through the ROM vector.
module fetch_ctrl #(
  parameter logic [3:0] TWO_BYTE_MIN = 4'hC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] vec,
  input  logic [7:0] instr,
  input  logic [7:0] next_byte,
  input  logic       interrupt,
  input  logic       stall,
  input  logic       br_taken,
  input  logic [7:0] br_target,
  input  logic       rti,
  output logic [7:0] pc,
  output logic [7:0] if_instr,
  output logic [7:0] if_imm,
  output logic       if_valid,
  output logic       int_ack,
  output logic [7:0] ret_pc
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    INTV = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [7:0] boot_pc;
  logic [7:0] pc_nx, instr_nx, imm_nx, ret_nx;
  logic       valid_nx, ack_nx;
  logic       ie, ie_nx;
  logic       pending, pending_nx;
  logic       int_q;
  logic       int_edge;

  assign int_edge = interrupt & ~int_q;

  // State register; boot_pc samples the vector (mem[0]) on every reset cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= BOOT;
      pc       <= 8'h00;
      if_instr <= 8'h00;
      if_imm   <= 8'h00;
      if_valid <= 1'b0;
      int_ack  <= 1'b0;
      ret_pc   <= 8'h00;
      ie       <= 1'b1;
      pending  <= 1'b0;
      int_q    <= 1'b0;
      boot_pc  <= vec;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      if_instr <= instr_nx;
      if_imm   <= imm_nx;
      if_valid <= valid_nx;
      int_ack  <= ack_nx;
      ret_pc   <= ret_nx;
      ie       <= ie_nx;
      pending  <= pending_nx;
      int_q    <= interrupt;
    end
  end

  // An edge arriving in the same cycle the pending flag is consumed is kept.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    instr_nx   = if_instr;
    imm_nx     = if_imm;
    valid_nx   = if_valid;
    ack_nx     = 1'b0;
    ret_nx     = ret_pc;
    ie_nx      = ie;
    pending_nx = pending | int_edge;

    case (state)
      BOOT: begin
        pc_nx    = boot_pc;
        valid_nx = 1'b0;
        state_nx = RUN;
      end
      INTV: begin
        pc_nx    = vec;
        valid_nx = 1'b0;
        state_nx = RUN;
      end
      RUN: begin
        if (stall) begin
          pc_nx = pc;
        end else if (rti) begin
          pc_nx    = ret_pc;
          ie_nx    = 1'b1;
          valid_nx = 1'b0;
        end else if (br_taken) begin
          pc_nx    = br_target;
          valid_nx = 1'b0;
        end else if (pending && ie) begin
          ret_nx     = pc;
          ie_nx      = 1'b0;
          pending_nx = int_edge;
          ack_nx     = 1'b1;
          valid_nx   = 1'b0;
          state_nx   = INTV;
        end else begin
          instr_nx = instr;
          imm_nx   = next_byte;
          valid_nx = 1'b1;
          pc_nx    = pc + ((instr[7:4] >= TWO_BYTE_MIN) ? 8'd2 : 8'd1);
        end
      end
      default: begin
        state_nx = BOOT;
      end
    endcase
  end

endmodule
